// File: rtl/ie_exec_ctrl_pkg.sv
// Shared definitions for the 6502 execute sequencer: FSM states, instruction
// classes and the select encodings seen by the memory bus and register file.
package ie_defs;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_STORE,
        S_PUSH,
        S_PULL,
        S_VEC,
        S_PCUPD,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_MEM,
        CLS_BRANCH,
        CLS_STACK,
        CLS_JSR,
        CLS_RTS,
        CLS_RTI,
        CLS_BRK
    } class_t;

    localparam logic [2:0] ADDR_OPERAND    = 3'd0;
    localparam logic [2:0] ADDR_STACK_PUSH = 3'd1;
    localparam logic [2:0] ADDR_STACK_PULL = 3'd2;
    localparam logic [2:0] ADDR_VEC_LO     = 3'd3;
    localparam logic [2:0] ADDR_VEC_HI     = 3'd4;

    localparam logic [1:0] PUSH_PCH = 2'd0;
    localparam logic [1:0] PUSH_PCL = 2'd1;
    localparam logic [1:0] PUSH_P   = 2'd2;
    localparam logic [1:0] PUSH_ALU = 2'd3;

    localparam logic [1:0] PULL_P     = 2'd0;
    localparam logic [1:0] PULL_PCL   = 2'd1;
    localparam logic [1:0] PULL_PCH   = 2'd2;
    localparam logic [1:0] PULL_ALU_B = 2'd3;

    localparam logic [1:0] PC_REL           = 2'd0;
    localparam logic [1:0] PC_ABS           = 2'd1;
    localparam logic [1:0] PC_PULLED_PLUS1  = 2'd2;
    localparam logic [1:0] PC_PULLED_OR_VEC = 2'd3;

    // Resolve overlapping decoder flags; an instruction with no class flag behaves as a NOP.
    function automatic class_t classify(
        input logic brk,
        input logic rti,
        input logic rts,
        input logic jsr,
        input logic stack_op,
        input logic branch,
        input logic nop,
        input logic flag_inst,
        input logic load,
        input logic store
    );
        if (brk)                   return CLS_BRK;
        else if (rti)              return CLS_RTI;
        else if (rts)              return CLS_RTS;
        else if (jsr)              return CLS_JSR;
        else if (stack_op)         return CLS_STACK;
        else if (branch)           return CLS_BRANCH;
        else if (nop || flag_inst) return CLS_NOP;
        else if (load || store)    return CLS_MEM;
        else                       return CLS_NOP;
    endfunction

endpackage

// File: rtl/ie_exec_ctrl.sv
// Multi-cycle execute sequencer: walks one decoded 6502 instruction through
// operand access, ALU, stack push/pull, vector fetch and PC update.
module ie_exec_ctrl
    import ie_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       is_load,
    input  logic       is_store,
    input  logic       is_branch,
    input  logic       is_jsr,
    input  logic       is_rts,
    input  logic       is_rti,
    input  logic       is_break,
    input  logic       is_stack_op,
    input  logic       is_nop,
    input  logic       is_flag_inst,
    input  logic       is_push,
    input  logic       branch_taken,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic [2:0] mem_addr_sel,
    output logic [1:0] push_sel,
    output logic [1:0] pull_sel,
    output logic       alu_en,
    output logic       reg_wr,
    output logic       sp_inc,
    output logic       sp_dec,
    output logic       pc_load,
    output logic [1:0] pc_sel,
    output logic       set_i,
    output logic       busy,
    output logic       done
);

    state_t     state;
    class_t     cls;
    logic       lat_store;
    logic       lat_flag;
    logic [1:0] cnt;

    class_t     start_cls;
    state_t     first_state;
    logic [1:0] push_last;
    logic [1:0] pull_last;

    // With is_stack_op, is_flag_inst marks the status-register variant (PHP/PLP).
    always_comb begin
        start_cls = classify(is_break, is_rti, is_rts, is_jsr, is_stack_op,
                             is_branch, is_nop, is_flag_inst, is_load, is_store);
        first_state = S_EXEC;
        case (start_cls)
            CLS_BRK, CLS_JSR: first_state = S_PUSH;
            CLS_RTI, CLS_RTS: first_state = S_PULL;
            CLS_STACK:        first_state = is_push ? S_PUSH : S_PULL;
            CLS_MEM:          first_state = is_load ? S_LOAD : S_EXEC;
            default:          first_state = S_EXEC;
        endcase
    end

    always_comb begin
        push_last = 2'd0;
        pull_last = 2'd0;
        if (cls == CLS_BRK)      push_last = 2'd2;
        else if (cls == CLS_JSR) push_last = 2'd1;
        if (cls == CLS_RTI)      pull_last = 2'd2;
        else if (cls == CLS_RTS) pull_last = 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cls       <= CLS_NOP;
            lat_store <= 1'b0;
            lat_flag  <= 1'b0;
            cnt       <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cls       <= start_cls;
                        lat_store <= is_store;
                        lat_flag  <= is_flag_inst;
                        cnt       <= 2'd0;
                        state     <= first_state;
                    end
                end
                S_LOAD: begin
                    if (mem_ack) state <= S_EXEC;
                end
                S_EXEC: begin
                    cnt   <= 2'd0;
                    state <= (cls == CLS_MEM && lat_store) ? S_STORE : S_DONE;
                end
                S_STORE: begin
                    if (mem_ack) state <= S_DONE;
                end
                S_PUSH: begin
                    if (mem_ack) begin
                        if (cnt == push_last) begin
                            cnt <= 2'd0;
                            case (cls)
                                CLS_BRK: state <= S_VEC;
                                CLS_JSR: state <= S_PCUPD;
                                default: state <= S_DONE;
                            endcase
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                S_PULL: begin
                    if (mem_ack) begin
                        if (cnt == pull_last) begin
                            cnt   <= 2'd0;
                            state <= (cls == CLS_STACK) ? S_EXEC : S_PCUPD;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                S_VEC: begin
                    if (mem_ack) begin
                        if (cnt == 2'd1) begin
                            cnt   <= 2'd0;
                            state <= S_PCUPD;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                S_PCUPD: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus controls depend only on state and cnt so they hold steady through wait cycles.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = ADDR_OPERAND;
        push_sel     = PUSH_PCH;
        pull_sel     = PULL_P;
        alu_en       = 1'b0;
        reg_wr       = 1'b0;
        sp_inc       = 1'b0;
        sp_dec       = 1'b0;
        pc_load      = 1'b0;
        pc_sel       = PC_REL;
        set_i        = 1'b0;
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        case (state)
            S_LOAD: begin
                mem_req      = 1'b1;
                mem_addr_sel = ADDR_OPERAND;
            end
            S_EXEC: begin
                case (cls)
                    CLS_BRANCH: begin
                        pc_load = branch_taken;
                        pc_sel  = PC_REL;
                    end
                    CLS_NOP: alu_en = lat_flag;
                    CLS_MEM: begin
                        alu_en = 1'b1;
                        reg_wr = ~lat_store;
                    end
                    CLS_STACK: begin
                        alu_en = 1'b1;
                        reg_wr = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_STORE: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = ADDR_OPERAND;
                push_sel     = PUSH_ALU;
            end
            S_PUSH: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = ADDR_STACK_PUSH;
                sp_dec       = mem_ack;
                if (cls == CLS_STACK) begin
                    push_sel = lat_flag ? PUSH_P : PUSH_ALU;
                end else begin
                    case (cnt)
                        2'd0:    push_sel = PUSH_PCH;
                        2'd1:    push_sel = PUSH_PCL;
                        default: push_sel = PUSH_P;
                    endcase
                end
            end
            S_PULL: begin
                mem_req      = 1'b1;
                mem_addr_sel = ADDR_STACK_PULL;
                sp_inc       = mem_ack;
                case (cls)
                    CLS_STACK: pull_sel = lat_flag ? PULL_P : PULL_ALU_B;
                    CLS_RTI: begin
                        case (cnt)
                            2'd0:    pull_sel = PULL_P;
                            2'd1:    pull_sel = PULL_PCL;
                            default: pull_sel = PULL_PCH;
                        endcase
                    end
                    default: pull_sel = (cnt == 2'd0) ? PULL_PCL : PULL_PCH;
                endcase
            end
            S_VEC: begin
                mem_req      = 1'b1;
                mem_addr_sel = (cnt == 2'd0) ? ADDR_VEC_LO : ADDR_VEC_HI;
                pull_sel     = (cnt == 2'd0) ? PULL_PCL : PULL_PCH;
            end
            S_PCUPD: begin
                pc_load = 1'b1;
                set_i   = (cls == CLS_BRK);
                case (cls)
                    CLS_JSR: pc_sel = PC_ABS;
                    CLS_RTS: pc_sel = PC_PULLED_PLUS1;
                    default: pc_sel = PC_PULLED_OR_VEC;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ie_exec_ctrl.sv
// Self-checking bench for ie_exec_ctrl: directed latency/reset cases plus random
// instructions compared cycle by cycle against a per-instruction access-list model.
module tb_ie_exec_ctrl;
    import ie_defs::*;

    typedef struct packed {
        logic brk, rti, rts, jsr, stk, push, br, nop, flag, ld, st;
    } instr_t;

    // One expected cycle: either a bus access (possibly stretched by wait states) or a plain step.
    typedef struct {
        logic       mem;
        logic       we;
        logic [2:0] addr;
        logic [1:0] psel;
        logic       cps;
        logic [1:0] lsel;
        logic       cls;
        logic       inc;
        logic       dec;
        logic       alu;
        logic       rw;
        logic       pcl;
        logic [1:0] pcs;
        logic       seti;
    } step_t;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       is_load, is_store, is_branch, is_jsr, is_rts, is_rti;
    logic       is_break, is_stack_op, is_nop, is_flag_inst, is_push;
    logic       branch_taken;
    logic       mem_ack;
    logic       mem_req, mem_we;
    logic [2:0] mem_addr_sel;
    logic [1:0] push_sel, pull_sel, pc_sel;
    logic       alu_en, reg_wr, sp_inc, sp_dec, pc_load, set_i, busy, done;

    int checks = 0;
    int failures = 0;
    step_t model[$];

    always #5 clk = ~clk;

    ie_exec_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .is_jsr(is_jsr), .is_rts(is_rts), .is_rti(is_rti),
        .is_break(is_break), .is_stack_op(is_stack_op), .is_nop(is_nop),
        .is_flag_inst(is_flag_inst), .is_push(is_push),
        .branch_taken(branch_taken), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .push_sel(push_sel), .pull_sel(pull_sel), .alu_en(alu_en),
        .reg_wr(reg_wr), .sp_inc(sp_inc), .sp_dec(sp_dec),
        .pc_load(pc_load), .pc_sel(pc_sel), .set_i(set_i),
        .busy(busy), .done(done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input instr_t f, input logic st);
        start        = st;
        is_break     = f.brk;
        is_rti       = f.rti;
        is_rts       = f.rts;
        is_jsr       = f.jsr;
        is_stack_op  = f.stk;
        is_push      = f.push;
        is_branch    = f.br;
        is_nop       = f.nop;
        is_flag_inst = f.flag;
        is_load      = f.ld;
        is_store     = f.st;
    endtask

    function automatic step_t acc(logic we, logic [2:0] addr, logic [1:0] psel, logic cps,
                                  logic [1:0] lsel, logic cls, logic inc, logic dec);
        step_t s = '{default: '0};
        s.mem = Y; s.we = we; s.addr = addr; s.psel = psel; s.cps = cps;
        s.lsel = lsel; s.cls = cls; s.inc = inc; s.dec = dec;
        return s;
    endfunction

    function automatic step_t wrk(logic alu, logic rw, logic pcl, logic [1:0] pcs, logic seti);
        step_t s = '{default: '0};
        s.alu = alu; s.rw = rw; s.pcl = pcl; s.pcs = pcs; s.seti = seti;
        return s;
    endfunction

    // Expected bus accesses and strobes for one instruction, straight from the class rules.
    function automatic void buildModel(instr_t f, logic taken);
        model.delete();
        if (f.brk) begin
            model.push_back(acc(Y, ADDR_STACK_PUSH, PUSH_PCH, Y, 2'd0, N, N, Y));
            model.push_back(acc(Y, ADDR_STACK_PUSH, PUSH_PCL, Y, 2'd0, N, N, Y));
            model.push_back(acc(Y, ADDR_STACK_PUSH, PUSH_P,   Y, 2'd0, N, N, Y));
            model.push_back(acc(N, ADDR_VEC_LO, 2'd0, N, 2'd0, N, N, N));
            model.push_back(acc(N, ADDR_VEC_HI, 2'd0, N, 2'd0, N, N, N));
            model.push_back(wrk(N, N, Y, PC_PULLED_OR_VEC, Y));
        end else if (f.rti) begin
            model.push_back(acc(N, ADDR_STACK_PULL, 2'd0, N, PULL_P,   Y, Y, N));
            model.push_back(acc(N, ADDR_STACK_PULL, 2'd0, N, PULL_PCL, Y, Y, N));
            model.push_back(acc(N, ADDR_STACK_PULL, 2'd0, N, PULL_PCH, Y, Y, N));
            model.push_back(wrk(N, N, Y, PC_PULLED_OR_VEC, N));
        end else if (f.rts) begin
            model.push_back(acc(N, ADDR_STACK_PULL, 2'd0, N, PULL_PCL, Y, Y, N));
            model.push_back(acc(N, ADDR_STACK_PULL, 2'd0, N, PULL_PCH, Y, Y, N));
            model.push_back(wrk(N, N, Y, PC_PULLED_PLUS1, N));
        end else if (f.jsr) begin
            model.push_back(acc(Y, ADDR_STACK_PUSH, PUSH_PCH, Y, 2'd0, N, N, Y));
            model.push_back(acc(Y, ADDR_STACK_PUSH, PUSH_PCL, Y, 2'd0, N, N, Y));
            model.push_back(wrk(N, N, Y, PC_ABS, N));
        end else if (f.stk) begin
            if (f.push) begin
                model.push_back(acc(Y, ADDR_STACK_PUSH, PUSH_ALU, !f.flag, 2'd0, N, N, Y));
            end else begin
                model.push_back(acc(N, ADDR_STACK_PULL, 2'd0, N, PULL_ALU_B, !f.flag, Y, N));
                model.push_back(wrk(Y, Y, N, 2'd0, N));
            end
        end else if (f.br) begin
            model.push_back(wrk(N, N, taken, PC_REL, N));
        end else if (f.nop || f.flag) begin
            model.push_back(wrk(f.flag, N, N, 2'd0, N));
        end else begin
            if (f.ld) model.push_back(acc(N, ADDR_OPERAND, 2'd0, N, 2'd0, N, N, N));
            model.push_back(wrk(Y, !f.st, N, 2'd0, N));
            if (f.st) model.push_back(acc(Y, ADDR_OPERAND, 2'd0, N, 2'd0, N, N, N));
        end
    endfunction

    task automatic checkCycle(input step_t s, input logic acked);
        checkOutput("mem_req", mem_req, s.mem);
        if (s.mem) begin
            checkOutput("mem_we", mem_we, s.we);
            checkOutput("mem_addr_sel", mem_addr_sel, s.addr);
            if (s.cps) checkOutput("push_sel", push_sel, s.psel);
            if (s.cls) checkOutput("pull_sel", pull_sel, s.lsel);
        end
        checkOutput("alu_en", alu_en, s.alu);
        checkOutput("reg_wr", reg_wr, s.rw);
        checkOutput("pc_load", pc_load, s.pcl);
        if (s.pcl) checkOutput("pc_sel", pc_sel, s.pcs);
        checkOutput("set_i", set_i, s.seti);
        checkOutput("sp_inc", sp_inc, s.inc & acked);
        checkOutput("sp_dec", sp_dec, s.dec & acked);
        checkOutput("busy", busy, Y);
        checkOutput("done_early", done, N);
    endtask

    // Runs one instruction from IDLE; called and returns at posedge+1 with the DUT idle.
    task automatic runInstr(input instr_t f, input logic taken, input int wmin, input int wmax,
                            output int lat, output int n_inc, output int n_dec);
        int w;
        buildModel(f, taken);
        n_inc = 0;
        n_dec = 0;
        applyStimulus(f, Y);
        branch_taken = taken;
        mem_ack = 1'($urandom_range(0, 1));
        #1;
        checkOutput("idle_busy", busy, N);
        @(posedge clk); #1;
        lat = 1;
        foreach (model[i]) begin
            w = model[i].mem ? int'($urandom_range(wmin, wmax)) : 0;
            for (int k = 0; k <= w; k++) begin
                applyStimulus(instr_t'(11'($urandom)), 1'($urandom_range(0, 1)));
                mem_ack = model[i].mem ? (k == w) : 1'($urandom_range(0, 1));
                #1;
                checkCycle(model[i], mem_ack);
                n_inc += int'(sp_inc);
                n_dec += int'(sp_dec);
                @(posedge clk); #1;
                lat++;
            end
        end
        start = N;
        mem_ack = N;
        #1;
        checkOutput("done_pulse", done, Y);
        checkOutput("done_busy", busy, Y);
        checkOutput("done_req", mem_req, N);
        @(posedge clk); #1;
        checkOutput("after_done", {busy, done}, 2'b00);
    endtask

    initial begin
        instr_t f;
        int lat, n_inc, n_dec, incs;

        rst = Y;
        applyStimulus(instr_t'(11'h7ff), Y);
        branch_taken = Y;
        mem_ack = Y;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    {mem_req, mem_we, mem_addr_sel, push_sel, pull_sel, alu_en, reg_wr,
                     sp_inc, sp_dec, pc_load, pc_sel, set_i, busy, done}, 32'd0);
        rst = N;
        start = N;

        f = '0; f.nop = Y;
        runInstr(f, N, 0, 0, lat, n_inc, n_dec);
        checkOutput("lat_nop", lat, 2);

        f = '0; f.ld = Y;
        runInstr(f, N, 0, 0, lat, n_inc, n_dec);
        checkOutput("lat_load", lat, 3);

        f = '0; f.ld = Y;
        runInstr(f, N, 3, 3, lat, n_inc, n_dec);
        checkOutput("lat_load_wait3", lat, 6);

        f = '0; f.ld = Y; f.st = Y;
        runInstr(f, N, 0, 0, lat, n_inc, n_dec);
        checkOutput("lat_load_store", lat, 4);

        f = '0; f.jsr = Y;
        runInstr(f, N, 0, 0, lat, n_inc, n_dec);
        checkOutput("lat_jsr", lat, 4);
        checkOutput("jsr_sp_dec", n_dec, 2);

        f = '0; f.rti = Y;
        runInstr(f, N, 0, 0, lat, n_inc, n_dec);
        checkOutput("lat_rti", lat, 5);

        f = '0; f.brk = Y; f.rts = Y; f.ld = Y;
        runInstr(f, N, 0, 0, lat, n_inc, n_dec);
        checkOutput("lat_brk", lat, 7);
        checkOutput("brk_sp_dec", n_dec, 3);
        checkOutput("brk_sp_inc", n_inc, 0);

        f = '0; f.br = Y;
        runInstr(f, N, 0, 0, lat, n_inc, n_dec);
        checkOutput("lat_branch_nt", lat, 2);
        runInstr(f, Y, 0, 0, lat, n_inc, n_dec);
        checkOutput("lat_branch_t", lat, 2);

        // RTI aborted by reset while the second pull is still waiting for ack.
        f = '0; f.rti = Y;
        incs = 0;
        applyStimulus(f, Y);
        mem_ack = N;
        @(posedge clk); #1;
        start = N;
        mem_ack = Y;
        #1;
        incs += int'(sp_inc);
        @(posedge clk); #1;
        mem_ack = N;
        #1;
        checkOutput("rti_second_pull_req", mem_req, Y);
        @(posedge clk); #1;
        rst = Y;
        #1;
        incs += int'(sp_inc);
        @(posedge clk); #1;
        checkOutput("rst_req_drop", mem_req, N);
        checkOutput("rst_idle", busy, N);
        checkOutput("rst_no_done", done, N);
        rst = N;
        mem_ack = Y;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checkOutput("rst_quiet", {busy, done, mem_req}, 3'b000);
        end
        checkOutput("rst_sp_inc_count", incs, 1);

        for (int n = 0; n < 200; n++) begin
            f = instr_t'(11'($urandom & $urandom));
            if (!(f.brk | f.rti | f.rts | f.jsr | f.stk | f.br | f.nop | f.flag | f.ld | f.st))
                f.nop = Y;
            runInstr(f, 1'($urandom_range(0, 1)), 0, 3, lat, n_inc, n_dec);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ie_exec_ctrl.md
# ie_exec_ctrl

Multi-cycle execute sequencer for the 6502 instruction-execute (IE) unit. It sits between the simple-op decoder and the memory bus and register file. It takes the decoded class flags for one instruction and steps it through operand load, ALU, store, stack push/pull and PC update. It issues one memory access at a time over a req/ack handshake and pulses the matching register, stack-pointer and PC strobes.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  decoded instruction valid; accepted only when busy=0
- is_load, is_store, is_branch, is_jsr, is_rts, is_rti, is_break, is_stack_op, is_nop, is_flag_inst  in  1 each  decoder class flags, sampled with start
- is_push  in  1  with is_stack_op: 1=push (PHA/PHP), 0=pull (PLA/PLP)
- branch_taken  in  1  condition result, valid during EXEC
- mem_ack  in  1  current access complete; ignored when mem_req=0
- mem_req  out  1  access request, held until ack
- mem_we  out  1  1=write
- mem_addr_sel  out  3  OPERAND, STACK_PUSH (0x0100|SP), STACK_PULL (0x0100|(SP+1)), VEC_LO (0xFFFE), VEC_HI (0xFFFF)
- push_sel  out  2  write data: PCH, PCL, P, ALU
- pull_sel  out  2  pulled byte destination: P, PCL, PCH, ALU_B
- alu_en  out  1  ALU result and flags commit this cycle
- reg_wr  out  1  register-file writeback strobe
- sp_inc, sp_dec  out  1 each  stack-pointer strobes
- pc_load  out  1  PC load strobe
- pc_sel  out  2  REL, ABS, PULLED_PLUS1, PULLED_OR_VEC
- set_i  out  1  set interrupt-disable flag
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, LOAD, EXEC, STORE, PUSH, PULL, VEC, PCUPD, DONE.
- 2-bit byte counter `cnt` indexes push/pull/vector sequences. It is cleared on entry to each of those states.
- Class priority when more than one flag is set: break > rti > rts > jsr > stack_op > branch > nop/flag > load/store.
- IDLE with start: move to the first state of the class. Flags are latched; later input changes are ignored.
- nop/flag_inst: EXEC (alu_en=1 only for flag_inst) -> DONE.
- load/store: LOAD if is_load -> EXEC (alu_en, reg_wr unless is_store) -> STORE if is_store -> DONE.
- branch: EXEC. If branch_taken: pc_load=1, pc_sel=REL. Then DONE.
- jsr: PUSH PCH, PCL -> PCUPD (pc_sel=ABS) -> DONE.
- rts: PULL PCL, PCH -> PCUPD (PULLED_PLUS1) -> DONE.
- rti: PULL P, PCL, PCH -> PCUPD (PULLED_OR_VEC) -> DONE.
- break: PUSH PCH, PCL, P -> VEC (read LO, HI) -> PCUPD (PULLED_OR_VEC, set_i=1) -> DONE.
- stack_op push: PUSH ALU/P (PHA uses ALU; PHP uses P via push_sel) -> DONE.
- stack_op pull: PULL ALU_B/P -> EXEC (alu_en, reg_wr) -> DONE.
- sp_dec pulses in the cycle a push is acked (post-decrement).
- sp_inc pulses in the cycle a pull is acked. Pull addressing uses SP+1, so the strobe commits the pre-increment.

## Timing
- Reset values: all outputs 0, state IDLE, cnt 0.
- rst mid-operation returns to IDLE next edge, drops mem_req without waiting for ack, and emits no done.
- Handshake: mem_req, mem_we, mem_addr_sel and push_sel are stable while mem_req=1 and mem_ack=0.
  - A cycle with req&ack completes the access.
  - The next cycle starts the next access or the next state.
  - A zero-wait memory (ack tied 1) gives one access per cycle.
- busy rises the cycle after start. start while busy=1 is ignored.
- done pulses for one cycle in DONE. IDLE follows. A new start can be accepted the cycle after done.
- Minimum latencies, start edge to done cycle, with zero-wait memory:
  - NOP: 2 cycles.
  - Load + ALU: 3 cycles.
  - Load + ALU + store: 4 cycles.
  - JSR: 4 cycles.
  - RTI: 5 cycles.
  - BRK: 7 cycles.
- Strobes (alu_en, reg_wr, pc_load, sp_*, set_i) are single-cycle pulses.

## Structure
- Add to package ie_defs:
  - FSM state enum;
  - encodings for mem_addr_sel, push_sel, pull_sel and pc_sel.
- Single module, no sub-modules: registered state, flag latch and cnt, with combinational output decode.

## Test plan
- NOP with ack tied 1: start=1 -> busy 1 cycle later, done 2 cycles after start, no mem_req, no strobes.
- LDA-style load + ALU, ack delayed 3 cycles:
  - mem_req held 4 cycles with addr_sel=OPERAND, we=0;
  - then alu_en=reg_wr=1 for one cycle;
  - done next.
- JSR, zero-wait:
  - two writes, push_sel PCH then PCL, addr_sel=STACK_PUSH, sp_dec on each;
  - then pc_load with pc_sel=ABS;
  - done at cycle 4.
- BRK:
  - pushes PCH/PCL/P;
  - reads VEC_LO then VEC_HI;
  - pc_load with set_i=1;
  - sp_dec count=3, sp_inc count=0.
- RTI with ack withheld mid-sequence, then rst=1 during the second pull: mem_req=0 and state IDLE next cycle, no done, sp_inc count=1.
- Branch with branch_taken=0 -> no pc_load, done at cycle 2. Same branch with branch_taken=1 -> pc_load with pc_sel=REL in EXEC.
